// File: rtl/glut_pkg.sv
// Shared definitions for the glut array post-processing blocks.
package glut_pkg;

  // Four fp32 lanes per 128-bit beat.
  localparam int unsigned FP_LANES = 4;
  localparam int unsigned LANE_W   = 32;

  // Default length of one max run in beats.
  localparam int unsigned DATA_NUM_DEFAULT = 192;

  // Pack block control states.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGap   = 2'd1,
    StRun   = 2'd2,
    StFlush = 2'd3
  } state_e;

endpackage

// File: rtl/max_pack_outreg.sv
// Single-entry valid/ready holding register. A load may coincide with an
// accept of the current word, giving back-to-back transfers with no bubble.
// The caller must not load while full and not being accepted.
module max_pack_outreg #(
  parameter int unsigned Width = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [Width-1:0] i_data,
  input  logic             i_last,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [Width-1:0] o_data,
  output logic             o_last,
  output logic             o_full
);

  logic             r_valid_q;
  logic [Width-1:0] r_data_q;
  logic             r_last_q;

  // Load a new word, or empty once the current word is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_last_q  <= 1'b0;
    end else if (i_load) begin
      r_valid_q <= 1'b1;
      r_data_q  <= i_data;
      r_last_q  <= i_last;
    end else if (r_valid_q && i_ready) begin
      r_valid_q <= 1'b0;
    end
  end

  assign o_valid = r_valid_q;
  assign o_data  = r_data_q;
  assign o_last  = r_last_q;
  assign o_full  = r_valid_q;

endmodule

// File: rtl/max_pack_block.sv
// Packs one fp32 maximum per completed max run into 128-bit words.
// Optional lane consistency check enabled by defining MAX_PACK_LANE_CHECK_EN.
module max_pack_block
  import glut_pkg::*;
#(
  parameter int unsigned DATA_NUM = DATA_NUM_DEFAULT,
  parameter int unsigned PACK_NUM = 4,
  parameter int unsigned CNT_W    = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stage_start,
  input  logic         input_atvalid,
  input  logic [127:0] input_atdata,
  output logic         output_atvalid,
  input  logic         output_atready,
  output logic [127:0] output_atdata,
  output logic         output_atlast,
  output logic         overflow_err,
  output logic         short_run_err,
  output logic         lane_err
);

  localparam int unsigned      WordW    = FP_LANES * LANE_W;
  localparam logic [CNT_W-1:0] RunLast  = CNT_W'(DATA_NUM - 1);
  localparam logic [1:0]       SlotLast = 2'(PACK_NUM - 1);

  state_e             r_state_q, r_state_d;
  logic               r_stage_q;
  logic [CNT_W-1:0]   r_run_cnt_q, r_run_cnt_d;
  logic [1:0]         r_slot_q, r_slot_d;
  logic [WordW-1:0]   r_pack_q, r_pack_d;
  logic               r_ovf_q, r_ovf_d;
  logic               r_short_q, r_short_d;

  logic               w_rise, w_fall, w_capture, w_complete, w_flush;
  logic               w_load_req, w_load, w_drop, w_full;
  logic [LANE_W-1:0]  w_lane0;
  logic [WordW-1:0]   w_word, w_load_data;

  // Stage edges, capture decode and the word being completed this cycle.
  always_comb begin
    w_rise    = stage_start & ~r_stage_q;
    w_fall    = ~stage_start & r_stage_q;
    w_lane0   = input_atdata[LANE_W-1:0];
    w_capture = stage_start & ~w_rise & (r_state_q == StGap) & input_atvalid;
    w_word    = r_pack_q;
    w_word[int'(r_slot_q)*LANE_W +: LANE_W] = w_lane0;
    w_complete  = w_capture & (r_slot_q == SlotLast);
    w_flush     = (r_state_q == StFlush) & (r_slot_q != 2'd0);
    w_load_req  = w_complete | w_flush;
    // Capture needs StGap and flush needs StFlush, so at most one source.
    w_load_data = w_complete ? w_word : r_pack_q;
    w_drop      = w_load_req & w_full & ~output_atready;
    w_load      = w_load_req & ~w_drop;
  end

  // Run/stage FSM, slot packing and sticky error next-state.
  always_comb begin
    r_state_d   = r_state_q;
    r_run_cnt_d = r_run_cnt_q;
    r_slot_d    = r_slot_q;
    r_pack_d    = r_pack_q;
    r_ovf_d     = r_ovf_q;
    r_short_d   = r_short_q;

    if (w_rise) begin
      r_state_d   = StGap;
      r_run_cnt_d = '0;
      r_slot_d    = 2'd0;
      r_pack_d    = '0;
      r_ovf_d     = 1'b0;
      r_short_d   = 1'b0;
    end else if (w_fall) begin
      r_state_d = StFlush;
    end else begin
      unique case (r_state_q)
        StIdle: ;
        StGap: begin
          if (w_capture) begin
            r_state_d   = StRun;
            r_run_cnt_d = CNT_W'(1);
            if (w_complete) begin
              r_slot_d = 2'd0;
              r_pack_d = '0;
            end else begin
              r_slot_d = r_slot_q + 2'd1;
              r_pack_d = w_word;
            end
          end
        end
        StRun: begin
          if (input_atvalid) begin
            if (r_run_cnt_q == RunLast) begin
              r_run_cnt_d = '0;
              r_state_d   = StGap;
            end else begin
              r_run_cnt_d = r_run_cnt_q + CNT_W'(1);
            end
          end else begin
            // Run cut short: keep the captured max, flag it.
            r_short_d   = 1'b1;
            r_run_cnt_d = '0;
            r_state_d   = StGap;
          end
        end
        StFlush: begin
          r_state_d   = StIdle;
          r_run_cnt_d = '0;
          r_slot_d    = 2'd0;
          r_pack_d    = '0;
        end
        default: r_state_d = StIdle;
      endcase
    end

    if (w_drop) r_ovf_d = 1'b1;
  end

  // Control and pack state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q   <= StIdle;
      r_stage_q   <= 1'b0;
      r_run_cnt_q <= '0;
      r_slot_q    <= 2'd0;
      r_pack_q    <= '0;
      r_ovf_q     <= 1'b0;
      r_short_q   <= 1'b0;
    end else begin
      r_state_q   <= r_state_d;
      r_stage_q   <= stage_start;
      r_run_cnt_q <= r_run_cnt_d;
      r_slot_q    <= r_slot_d;
      r_pack_q    <= r_pack_d;
      r_ovf_q     <= r_ovf_d;
      r_short_q   <= r_short_d;
    end
  end

  max_pack_outreg #(
    .Width (WordW)
  ) u_outreg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_data  (w_load_data),
    .i_last  (w_flush),
    .i_ready (output_atready),
    .o_valid (output_atvalid),
    .o_data  (output_atdata),
    .o_last  (output_atlast),
    .o_full  (w_full)
  );

  assign overflow_err  = r_ovf_q;
  assign short_run_err = r_short_q;

`ifdef MAX_PACK_LANE_CHECK_EN
  logic w_lane_mis;
  logic r_lane_q;

  // Lanes 1..3 must replicate lane0 on the capture beat.
  always_comb begin
    w_lane_mis = 1'b0;
    for (int k = 1; k < FP_LANES; k++) begin
      if (input_atdata[k*LANE_W +: LANE_W] != w_lane0) w_lane_mis = 1'b1;
    end
  end

  // Sticky lane error, cleared at the start of each stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lane_q <= 1'b0;
    end else if (w_rise) begin
      r_lane_q <= 1'b0;
    end else if (w_capture && w_lane_mis) begin
      r_lane_q <= 1'b1;
    end
  end

  assign lane_err = r_lane_q;
`else
  logic w_unused_lanes;
  assign w_unused_lanes = ^input_atdata[WordW-1:LANE_W];
  assign lane_err       = 1'b0;
`endif

endmodule

// File: doc/max_pack_block.md
Name: max_pack_block

Overview:
- Sits directly downstream of the max block in the glut array and consumes one output port (west or south).
- Each completed max run is a burst of DATA_NUM consecutive valid beats, all carrying the same fp32 maximum replicated in all four 32-bit lanes.
- The block takes one 32-bit max per run and packs PACK_NUM maxima into one 128-bit word.
- It emits that word on a valid/ready output toward the result buffer, and flushes a partial word when the stage ends.

Parameters:
- DATA_NUM, 192: beats per max run; used for run counting and wrap.
- PACK_NUM, 4: maxima per output word; legal range 1..4.
- CNT_W, 10: run beat counter width; must satisfy 2^CNT_W > DATA_NUM.

Ports:
- clk, in, 1: clock; all logic on rising edge.
- rst, in, 1: asynchronous, active-high reset.
- stage_start, in, 1: level; high for the whole stage, same signal as fed to the max block.
- input_atvalid, in, 1: beat valid from the max block output port.
- input_atdata, in, 128: beat data, four fp32 lanes; lane0 = [31:0].
- output_atvalid, out, 1: packed word valid.
- output_atready, in, 1: downstream accept.
- output_atdata, out, 128: packed maxima; slot k = [32k+31:32k].
- output_atlast, out, 1: word is the final (flushed) word of the stage.
- overflow_err, out, 1: sticky; a completed word was dropped.
- short_run_err, out, 1: sticky; a run ended before DATA_NUM beats.
- lane_err, out, 1: sticky; lane mismatch (see Optional Feature).

Behaviour:
- Reset (async, any time, including mid-run): all outputs 0, state IDLE, counters 0, pack register 0, output holding register empty.
- Stage control:
  - stage_start rising edge: clear run_cnt, slot_idx and the pack register, and clear all sticky errors. Enter GAP.
  - While stage_start is low, input beats are ignored.
- FSM states IDLE, GAP, RUN, FLUSH:
  - IDLE -> GAP on stage_start rising edge.
  - GAP -> RUN on input_atvalid. This first beat is the capture beat: lane0 is written into slot slot_idx, run_cnt becomes 1.
  - In RUN, each valid beat increments run_cnt.
  - When run_cnt reaches DATA_NUM-1 and the current beat is valid, run_cnt wraps to 0 and the state returns to GAP. A valid beat on the next cycle therefore starts a new run with no gap required (back-to-back runs).
  - RUN with input_atvalid low before the count completes: set short_run_err, go to GAP. The captured value is kept.
  - stage_start falling edge in any state -> FLUSH. If slot_idx > 0, a word is emitted with unused slots zero and output_atlast=1. If slot_idx == 0, no word is emitted. Then go to IDLE.
- Packing:
  - On the capture beat with slot_idx == PACK_NUM-1, the completed word is assembled combinationally (current pack register plus the new lane0). It loads into the holding register on the same edge, so output_atvalid rises one cycle after the capture beat.
  - slot_idx then wraps to 0 and the pack register clears.
  - output_atlast=0 for full words, unless the stage ends on the same cycle. That simultaneous case yields one word with output_atlast=1, not two.
- Output handshake:
  - output_atdata and output_atlast stay stable while output_atvalid=1 and output_atready=0.
  - A transfer happens when both valid and ready are high. The holding register empties the next cycle unless reloaded on the same edge; simultaneous accept and load is legal and gives zero bubble.
- Overflow: if a word completes (or a flush occurs) while the holding register is full and not being accepted, drop the new word, set overflow_err, and keep the old word.
- Widths: lane0 is copied bit-exact with no fp32 arithmetic. run_cnt is CNT_W bits; slot_idx is 2 bits.

Optional Feature:
- Macro: MAX_PACK_LANE_CHECK_EN.
- Defined: on every capture beat, compare lanes 1..3 against lane0. Any mismatch sets lane_err (sticky until the next stage_start rising edge or rst). Data is still captured from lane0.
- Undefined: no comparators; lane_err tied to 0.

Decomposition:
- Shared package glut_pkg holds:
  - the FSM state enum (IDLE, GAP, RUN, FLUSH);
  - the constants FP_LANES=4 and LANE_W=32;
  - the default DATA_NUM=192.
- One natural sub-module, max_pack_outreg: the single-entry valid/ready holding register with a load/accept interface and a full flag. Everything else lives in max_pack_block.

Test Plan:
- Four runs of 192 beats each (lanes = 0x3F800000, 0x40000000, 0x40400000, 0x40800000), ready=1 -> one word {0x40800000,0x40400000,0x40000000,0x3F800000}. output_atvalid is high one cycle after the 4th run's first beat; output_atlast=0.
- Two runs, then stage_start falls -> one word {0,0,0x40000000,0x3F800000} with output_atlast=1; state returns to IDLE.
- Back-to-back: 384 consecutive valid beats, value A then B -> slots 0 and 1 hold A and B; short_run_err=0.
- Run of 100 beats then valid low -> short_run_err=1; value captured in slot 0; the next run goes to slot 1.
- ready=0 held while 8 runs complete -> first word held stable; second word dropped; overflow_err=1. Raise ready -> first word transfers exactly once.
- With MAX_PACK_LANE_CHECK_EN: capture beat lanes {1,1,2,1} -> lane_err=1. Then assert rst mid-run -> all outputs 0 immediately, before the next clk edge.
